// File: rtl/divmmc_ctrl_if.sv
// Z80 bus, I/O read return, mapping controls and SD-card SPI pins of the DivMMC controller.
// The master side is the CPU/board; the slave side is the controller.
interface divmmc_ctrl_if;
  logic        cpuCe;
  logic        iorq;
  logic        mreq;
  logic        m1;
  logic        rd;
  logic        wr;
  logic [15:0] a;
  logic [7:0]  di;
  logic [7:0]  dout;
  logic        doEn;
  logic        divMap;
  logic        divRam;
  logic [3:0]  divPage;
  logic        spiCs;
  logic        spiCk;
  logic        spiDo;
  logic        spiDi;
  logic [1:0]  spi_state;

  modport master (
    output cpuCe, iorq, mreq, m1, rd, wr, a, di, spiDi,
    input  dout, doEn, divMap, divRam, divPage, spiCs, spiCk, spiDo, spi_state
  );

  modport slave (
    input  cpuCe, iorq, mreq, m1, rd, wr, a, di, spiDi,
    output dout, doEn, divMap, divRam, divPage, spiCs, spiCk, spiDo, spi_state
  );
endinterface

// File: rtl/divmmc_ctrl.sv
// DivMMC controller: automap traps, 0xE3 paging port, and a mode-0 SPI master on 0xE7/0xEB.
// Mapping outputs are registered one clock behind the internal state.
module divmmc_ctrl #(
  parameter int SPIDIV = 1
) (
  input logic          clock,
  input logic          reset,
  divmmc_ctrl_if.slave bus
);
  localparam logic [7:0] PORT_CTRL = 8'hE3;
  localparam logic [7:0] PORT_CS   = 8'hE7;
  localparam logic [7:0] PORT_DATA = 8'hEB;
  localparam int         CW        = (SPIDIV > 1) ? $clog2(SPIDIV) : 1;

  typedef enum logic [1:0] {
    SPI_IDLE = 2'd0,
    SPI_LOW  = 2'd1,
    SPI_HIGH = 2'd2
  } spi_state_t;

  logic [7:0]  port;
  logic        io_wr, io_rd, io_wr_q, io_rd_q, wr_stb, rd_stb;
  logic        fetch, trap_map, trap_unmap, trap_instant;
  logic        conmem, mapram, automap, map_pend, unmap_pend;
  logic [3:0]  page;
  logic        map_q, ram_q, cs_q;
  logic [3:0]  page_q;
  spi_state_t  state, state_next;
  logic [CW-1:0] div_cnt;
  logic        div_done;
  logic [2:0]  bit_cnt;
  logic [7:0]  sr, rx;
  logic        bit_in, spi_start, spi_ck, spi_do;
  logic [7:0]  start_data;

  assign port  = bus.a[7:0];
  assign io_wr = !bus.iorq && !bus.wr && bus.m1;
  assign io_rd = !bus.iorq && !bus.rd && bus.m1;
  // Strobes fire once per access: only on the first cpuCe edge that sees them asserted.
  assign wr_stb = bus.cpuCe && io_wr && !io_wr_q;
  assign rd_stb = bus.cpuCe && io_rd && !io_rd_q;

  assign fetch        = bus.cpuCe && !bus.m1 && !bus.mreq;
  assign trap_instant = (bus.a[15:8] == 8'h3D);
  assign trap_unmap   = (bus.a[15:3] == 13'h03FF);
  always_comb begin
    trap_map = 1'b0;
    case (bus.a)
      16'h0000, 16'h0008, 16'h0038, 16'h0066, 16'h04C6, 16'h0562: trap_map = 1'b1;
      default: trap_map = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_wr_q <= 1'b0;
      io_rd_q <= 1'b0;
    end else if (bus.cpuCe) begin
      io_wr_q <= io_wr;
      io_rd_q <= io_rd;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      conmem <= 1'b0;
      mapram <= 1'b0;
      page   <= 4'd0;
      cs_q   <= 1'b1;
    end else if (wr_stb) begin
      if (port == PORT_CTRL) begin
        conmem <= bus.di[7];
        mapram <= mapram | bus.di[6];
        page   <= bus.di[3:0];
      end
      if (port == PORT_CS) cs_q <= bus.di[0];
    end
  end

  // Pending traps take effect once M1 ends, so the trapping opcode runs from the old mapping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      automap    <= 1'b0;
      map_pend   <= 1'b0;
      unmap_pend <= 1'b0;
    end else if (fetch) begin
      if (trap_map)     map_pend   <= 1'b1;
      if (trap_unmap)   unmap_pend <= 1'b1;
      if (trap_instant) automap    <= 1'b1;
    end else if (bus.cpuCe && bus.m1) begin
      if (unmap_pend)    automap <= 1'b0;
      else if (map_pend) automap <= 1'b1;
      map_pend   <= 1'b0;
      unmap_pend <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      map_q  <= 1'b0;
      ram_q  <= 1'b0;
      page_q <= 4'd0;
    end else begin
      map_q  <= conmem | automap;
      ram_q  <= mapram & !conmem;
      page_q <= page;
    end
  end

  assign spi_start  = (state == SPI_IDLE) && (port == PORT_DATA) && (wr_stb || rd_stb);
  assign start_data = wr_stb ? bus.di : 8'hFF;
  assign div_done   = (div_cnt == CW'(SPIDIV - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= SPI_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      SPI_IDLE: if (spi_start) state_next = SPI_LOW;
      SPI_LOW:  if (div_done)  state_next = SPI_HIGH;
      SPI_HIGH: if (div_done)  state_next = (bit_cnt == 3'd7) ? SPI_IDLE : SPI_LOW;
      default:                 state_next = SPI_IDLE;
    endcase
  end

  always_comb begin
    spi_ck = (state == SPI_HIGH);
    spi_do = (state == SPI_IDLE) ? 1'b1 : sr[7];
  end

  // MISO is captured on the rising edge and shifted in on the falling edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sr      <= 8'hFF;
      rx      <= 8'hFF;
      div_cnt <= '0;
      bit_cnt <= 3'd0;
      bit_in  <= 1'b1;
    end else begin
      case (state)
        SPI_IDLE: if (spi_start) begin
          sr      <= start_data;
          div_cnt <= '0;
          bit_cnt <= 3'd0;
        end
        SPI_LOW: if (div_done) begin
          bit_in  <= bus.spiDi;
          div_cnt <= '0;
        end else div_cnt <= div_cnt + 1'b1;
        SPI_HIGH: if (div_done) begin
          div_cnt <= '0;
          sr      <= {sr[6:0], bit_in};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) rx <= {sr[6:0], bit_in};
        end else div_cnt <= div_cnt + 1'b1;
        default: div_cnt <= '0;
      endcase
    end
  end

  always_comb begin
    bus.dout = 8'hFF;
    if (io_rd && port == PORT_CTRL)      bus.dout = {conmem, mapram, 2'b00, page};
    else if (io_rd && port == PORT_DATA) bus.dout = rx;
  end

  assign bus.doEn      = io_rd && (port == PORT_CTRL || port == PORT_DATA);
  assign bus.divMap    = map_q;
  assign bus.divRam    = ram_q;
  assign bus.divPage   = page_q;
  assign bus.spiCs     = cs_q;
  assign bus.spiCk     = spi_ck;
  assign bus.spiDo     = spi_do;
  assign bus.spi_state = state;
endmodule

// File: doc/divmmc_ctrl.md
Name: divmmc_ctrl

Overview:
- DivMMC interface controller; sits directly upstream of the memory block.
- Produces the divMap, divRam and divPage mapping controls that the memory block consumes, from Z80 bus snooping (automap traps) and the 0xE3 control port.
- Also contains the SD-card SPI master on ports 0xE7 (chip select) and 0xEB (data).
- Returns I/O read data to the CPU data-in mux.

Parameters:
SPIDIV, 1, SPI half-period in clock cycles; one bit takes 2*SPIDIV clocks.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
cpuCe  in  1  CPU clock enable; all bus sampling happens only on clock edges with cpuCe=1
iorq  in  1  Z80 IORQ, active low
mreq  in  1  Z80 MREQ, active low
m1  in  1  Z80 M1, active low
rd  in  1  Z80 RD, active low
wr  in  1  Z80 WR, active low
a  in  16  CPU address
di  in  8  CPU data out (write data)
do  out  8  I/O read data
doEn  out  1  high while a valid I/O read of 0xE3 or 0xEB is on the bus
divMap  out  1  DivMMC ROM/RAM mapped into 0x0000-0x3FFF
divRam  out  1  0x0000-0x1FFF served from RAM bank 3 instead of the DivMMC ROM
divPage  out  4  RAM bank mapped at 0x2000-0x3FFF
spiCs  out  1  SD chip select, active low
spiCk  out  1  SPI clock, mode 0
spiDo  out  1  MOSI
spiDi  in  1  MISO

Behaviour:
- Reset (async, reset=0):
  - conmem, mapram, automap and pending flags = 0; page = 0.
  - spiCs=1, spiCk=0, spiDo=1, rx=0xFF, busy=0.
  - mapram is cleared only by reset.
- Port decode: ioWr = !iorq && !wr && m1; ioRd = !iorq && !rd && m1; only a[7:0] is compared.
  - Each access acts exactly once: on the first cpuCe edge where the strobe is seen asserted (edge-detected against the previous sampled value).
- 0xE3 write:
  - conmem <= di[7].
  - mapram <= mapram | di[6] (sticky).
  - page <= di[3:0].
- 0xE3 read: do = {conmem, mapram, 2'b00, page}.
- 0xE7 write: spiCs <= di[0].
- 0xEB write: if !busy, load the shift register with di and start a transfer; writes while busy are ignored.
- 0xEB read: do = rx; if !busy, also start a transfer sending 0xFF.
- doEn = ioRd && (a[7:0]==0xE3 || a[7:0]==0xEB); do = 0xFF otherwise.
- Automap: an opcode fetch is m1=0 && mreq=0, sampled on cpuCe.
  - Fetch at 0x0000, 0x0008, 0x0038, 0x0066, 0x04C6 or 0x0562: set mapPend.
  - Fetch at 0x3D00-0x3DFF: automap <= 1 on that same cpuCe edge (instant).
  - Fetch at 0x1FF8-0x1FFF: set unmapPend.
  - On the first cpuCe edge with m1=1 after a fetch: mapPend -> automap=1, unmapPend -> automap=0, then both pends are cleared. The trapped instruction therefore executes from the previous mapping.
  - If both pends are set, unmap wins.
- Outputs (registered, update on the clock after the state change):
  - divMap = conmem | automap.
  - divRam = mapram & !conmem.
  - divPage = page.
- SPI master: mode 0, MSB first, 8 bits.
  - Each bit: spiDo is driven with the MSB while spiCk=0 for SPIDIV clocks.
  - spiCk then rises; spiDi is sampled into the LSB at the rise.
  - spiCk stays high for SPIDIV clocks, then falls and the register shifts.
  - After bit 7 falls: rx <= shifted byte, busy <= 0, spiCk=0, spiDo=1.
  - SPI runs on clock only, independent of cpuCe.
- Reset asserted mid-transfer aborts immediately to reset values; a partial byte is discarded.

Test Plan:
- Reset release -> divMap=0, divRam=0, divPage=0, spiCs=1, spiCk=0; read 0xE3 -> 0x00, doEn=1.
- OUT 0xE3,0xC5 -> divMap=1, divRam=0, divPage=5; then OUT 0xE3,0x05 -> divMap=0, divRam=1, read 0xE3 returns 0x45 (mapram sticky).
- M1 fetch at 0x0038 -> divMap stays 0 through the fetch cycle and becomes 1 after m1 deasserts; a later fetch at 0x1FFA -> divMap returns to 0 after that fetch completes.
- M1 fetch at 0x3D2A -> divMap=1 within the same fetch (next clock after the cpuCe edge); fetch at 0x0100 -> no change.
- SPIDIV=1, OUT 0xEB,0xA5 with spiDi tied to a pattern of 0x3C -> 16 clocks, 8 spiCk pulses, MOSI bits 1,0,1,0,0,1,0,1; IN 0xEB returns 0x3C and starts a 0xFF transfer.
- OUT 0xEB during busy -> ignored, MOSI unchanged; reset pulse mid-transfer -> spiCk=0, spiCs=1, rx=0xFF, mapram=0.
